// File: rtl/rr_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter_if
// Brief    : Request/grant bundle between requesters and rr_grant_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_grant_arbiter_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = $clog2(WIDTH)
);
    logic [WIDTH-1:0]      req;
    logic [WIDTH-1:0]      gnt;
    logic [ADDR_WIDTH-1:0] enc;
    logic                  valid;
    logic                  expired;

    modport master (output req, input gnt, input enc, input valid, input expired);
    modport slave  (input req, output gnt, output enc, output valid, output expired);
endinterface
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter
// Brief    : Registered round-robin arbiter with a maximum grant hold time.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = $clog2(WIDTH),
    parameter int MAX_HOLD   = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rr_grant_arbiter_if.slave  bus
);
    localparam int                    c_hold_w   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit                    c_limited  = (MAX_HOLD != 0);
    localparam logic [c_hold_w-1:0]   c_max_hold = c_hold_w'(MAX_HOLD);
    localparam logic [c_hold_w-1:0]   c_hold_one = c_hold_w'(1);
    localparam logic [ADDR_WIDTH-1:0] c_last     = ADDR_WIDTH'(WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_enc_one  = ADDR_WIDTH'(1);
    localparam logic [WIDTH-1:0]      c_one      = WIDTH'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_gnt;
    logic [ADDR_WIDTH-1:0] r_enc;
    logic                  r_valid;
    logic                  r_expired;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [c_hold_w-1:0]   r_hold_cnt;

    logic [ADDR_WIDTH-1:0] w_pick;
    logic                  w_any;
    int                    w_scan;
    logic                  w_owner_req;
    logic                  w_at_limit;
    logic [ADDR_WIDTH-1:0] w_next_ptr;

    // Rotating-priority scan starting at r_ptr, wrapping past WIDTH-1 to 0.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_scan = 0;
        for (int i = 0; i < WIDTH; i++) begin
            w_scan = int'(r_ptr) + i;
            if (w_scan >= WIDTH) begin
                w_scan = w_scan - WIDTH;
            end
            if (!w_any && bus.req[w_scan]) begin
                w_pick = ADDR_WIDTH'(w_scan);
                w_any  = 1'b1;
            end
        end
    end

    // r_enc always names the current owner while in S_GRANT.
    assign w_owner_req = bus.req[r_enc];
    assign w_at_limit  = c_limited && (r_hold_cnt == c_max_hold);
    assign w_next_ptr  = (r_enc == c_last) ? '0 : (r_enc + c_enc_one);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_enc      <= '0;
            r_valid    <= 1'b0;
            r_expired  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_expired <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state    <= S_GRANT;
                        r_gnt      <= c_one << w_pick;
                        r_enc      <= w_pick;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= c_hold_one;
                    end
                end
                S_GRANT: begin
                    // A voluntary release wins over the hold limit on the same edge.
                    if (!w_owner_req || w_at_limit) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= '0;
                        r_valid   <= 1'b0;
                        r_ptr     <= w_next_ptr;
                        r_expired <= w_owner_req;
                    end else if (c_limited && (r_hold_cnt != c_max_hold)) begin
                        r_hold_cnt <= r_hold_cnt + c_hold_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.enc     = r_enc;
    assign bus.valid   = r_valid;
    assign bus.expired = r_expired;
endmodule
`default_nettype wire
